// File: rtl/abus_avalon_bridge_v2.sv
// Saturn A-bus slave front end: synchronises the A-bus strobes, posts writes through a FIFO
// and turns cartridge reads into ordered, timeout-guarded Avalon-MM read transfers.
module abus_avalon_bridge_v2 #(
  parameter int ADDR_W      = 10,
  parameter int NUM_CS      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int WFIFO_DEPTH = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] abus_address,
  input  logic [NUM_CS-1:0] abus_chipselect,
  input  logic              abus_read,
  input  logic [1:0]        abus_write,
  input  logic [15:0]       abus_data_in,
  output logic [15:0]       abus_data_out,
  output logic              abus_data_oe,
  output logic              abus_waitrequest,
  output logic              abus_interrupt,
  input  logic [NUM_CS-1:0] irq_in,
  output logic [ADDR_W+2:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [1:0]        avm_byteenable,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              timeout_error,
  input  logic              error_clear
);
  localparam int SW = ADDR_W + NUM_CS + 19;
  localparam int EW = ADDR_W + 20;
  localparam int PW = $clog2(WFIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  // Strobes and chip selects reset to their inactive (high) level so no false edge follows reset
  localparam logic [SW-1:0] SYNC_IDLE = {{ADDR_W{1'b0}}, {NUM_CS{1'b1}}, 1'b1, 2'b11, 16'h0000};

  typedef enum logic [2:0] {IDLE, RD_FLUSH, RD_REQ, RD_WAIT, RD_HOLD} state_t;

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] s;
  logic [ADDR_W-1:0] addr_s;
  logic [NUM_CS-1:0] cs_s;
  logic rd_s;
  logic [1:0] wr_s;
  logic [15:0] din_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
    end else begin
      sync_q[0] <= {abus_address, abus_chipselect, abus_read, abus_write, abus_data_in};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign addr_s = s[SW-1 -: ADDR_W];
  assign cs_s   = s[NUM_CS+18:19];
  assign rd_s   = s[18];
  assign wr_s   = s[17:16];
  assign din_s  = s[15:0];

  logic rd_prev_q, wr_act_prev_q, wr_act, rd_fall, wr_fall;
  logic [1:0] cs_idx;
  logic cs_valid;

  always_comb begin
    cs_idx   = 2'd0;
    cs_valid = 1'b0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (!cs_s[i]) begin
        cs_idx   = 2'(i);
        cs_valid = 1'b1;
      end
    end
  end

  assign wr_act  = ~&wr_s;
  assign rd_fall = rd_prev_q & ~rd_s;
  assign wr_fall = wr_act & ~wr_act_prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_prev_q     <= 1'b1;
      wr_act_prev_q <= 1'b0;
    end else begin
      rd_prev_q     <= rd_s;
      wr_act_prev_q <= wr_act;
    end
  end

  // Posted-write FIFO; a write that finds it full parks in pend_q until a slot frees up
  logic [EW-1:0] fifo_mem [WFIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0] count_q;
  logic [EW-1:0] new_entry, push_entry, pend_entry_q, head;
  logic pend_q, want, push, pop, empty, full, rd_active;
  state_t state_q;

  assign new_entry  = {cs_idx, addr_s, ~wr_s, din_s};
  assign empty      = (count_q == '0);
  assign full       = (count_q == (PW+1)'(WFIFO_DEPTH));
  assign want       = pend_q | (wr_fall & cs_valid);
  assign push_entry = pend_q ? pend_entry_q : new_entry;
  assign pop        = avm_write & ~avm_waitrequest;
  assign push       = want & (~full | pop);
  assign head       = fifo_mem[rptr_q];
  assign rd_active  = (state_q == RD_REQ) || (state_q == RD_WAIT);

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wptr_q] <= push_entry;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      pend_q       <= 1'b0;
      pend_entry_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (want && !push) begin
        pend_q <= 1'b1;
        if (!pend_q) pend_entry_q <= new_entry;
      end else if (push) begin
        pend_q <= 1'b0;
      end
    end
  end

  logic [ADDR_W+2:0] rd_addr_q;
  logic [15:0] data_q;
  logic [TW-1:0] tmo_cnt_q;
  logic avm_read_q, rd_wait_q, oe_q, abort_q, timeout_error_q, irq_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      rd_addr_q       <= '0;
      data_q          <= 16'h0000;
      tmo_cnt_q       <= '0;
      avm_read_q      <= 1'b0;
      rd_wait_q       <= 1'b0;
      oe_q            <= 1'b0;
      abort_q         <= 1'b0;
      timeout_error_q <= 1'b0;
      irq_q           <= 1'b0;
    end else begin
      irq_q <= |irq_in;
      if (error_clear) timeout_error_q <= 1'b0;
      case (state_q)
        IDLE: if (rd_fall && cs_valid) begin
          state_q   <= RD_FLUSH;
          rd_addr_q <= {cs_idx, addr_s, 1'b0};
          rd_wait_q <= 1'b1;
          abort_q   <= 1'b0;
        end
        RD_FLUSH: begin
          if (rd_s) begin
            state_q   <= IDLE;
            rd_wait_q <= 1'b0;
          end else if (empty && !pend_q && !push) begin
            state_q    <= RD_REQ;
            avm_read_q <= 1'b1;
          end
        end
        RD_REQ: begin
          if (rd_s) abort_q <= 1'b1;
          if (!avm_waitrequest) begin
            avm_read_q <= 1'b0;
            tmo_cnt_q  <= '0;
            state_q    <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rd_s) abort_q <= 1'b1;
          if (avm_readdatavalid || tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            if (!avm_readdatavalid) timeout_error_q <= 1'b1;
            rd_wait_q <= 1'b0;
            // An abandoned read still finishes on Avalon, but its data never reaches the bus
            if (abort_q || rd_s) begin
              state_q <= IDLE;
            end else begin
              state_q <= RD_HOLD;
              data_q  <= avm_readdatavalid ? avm_readdata : 16'hFFFF;
              oe_q    <= 1'b1;
            end
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
        end
        RD_HOLD: if (rd_s) begin
          state_q <= IDLE;
          oe_q    <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign avm_write        = ~empty & ~rd_active;
  assign avm_read         = avm_read_q;
  assign avm_address      = avm_read_q ? rd_addr_q :
                            (avm_write ? {head[EW-1 -: ADDR_W+2], 1'b0} : '0);
  assign avm_byteenable   = avm_read_q ? 2'b11 : (avm_write ? head[17:16] : 2'b00);
  assign avm_writedata    = avm_write ? head[15:0] : 16'h0000;
  assign abus_waitrequest = pend_q | rd_wait_q;
  assign abus_data_oe     = oe_q;
  assign abus_data_out    = data_q;
  assign abus_interrupt   = irq_q;
  assign timeout_error    = timeout_error_q;
endmodule

// File: tb/tb_abus_avalon_bridge_v2.sv
// Directed bench for abus_avalon_bridge_v2 with a small Avalon slave model and write log.
module tb_abus_avalon_bridge_v2;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  abus_address;
  logic [2:0]  abus_chipselect;
  logic        abus_read;
  logic [1:0]  abus_write;
  logic [15:0] abus_data_in;
  logic [15:0] abus_data_out;
  logic        abus_data_oe;
  logic        abus_waitrequest;
  logic        abus_interrupt;
  logic [2:0]  irq_in;
  logic [12:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [1:0]  avm_byteenable;
  logic [15:0] avm_writedata;
  logic [15:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;
  logic        timeout_error;
  logic        error_clear;

  int errors = 0;
  int checks = 0;

  logic [30:0] wq [$];
  logic [15:0] mem [0:8191];
  int          rd_cnt = 0;
  int          wr_before_rd = 0;
  logic [12:0] rd_addr_seen = '0;
  bit          respond_en = 1'b1;

  always #5 clk = ~clk;

  abus_avalon_bridge_v2 dut (
    .clock(clk), .reset(reset),
    .abus_address(abus_address), .abus_chipselect(abus_chipselect),
    .abus_read(abus_read), .abus_write(abus_write), .abus_data_in(abus_data_in),
    .abus_data_out(abus_data_out), .abus_data_oe(abus_data_oe),
    .abus_waitrequest(abus_waitrequest), .abus_interrupt(abus_interrupt), .irq_in(irq_in),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest),
    .timeout_error(timeout_error), .error_clear(error_clear)
  );

  // Avalon slave: logs accepted writes, answers accepted reads one cycle later
  always @(posedge clk) begin
    avm_readdatavalid <= 1'b0;
    if (avm_write && !avm_waitrequest) begin
      wq.push_back({avm_address, avm_byteenable, avm_writedata});
      mem[avm_address] <= avm_writedata;
    end
    if (avm_read && !avm_waitrequest) begin
      rd_cnt       <= rd_cnt + 1;
      rd_addr_seen <= avm_address;
      wr_before_rd <= wq.size();
      if (respond_en) begin
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= mem[avm_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic end_strobes();
    abus_chipselect = 3'b111;
    abus_read       = 1'b1;
    abus_write      = 2'b11;
  endtask

  task automatic start_write(input int cs, input logic [9:0] a, input logic [15:0] d,
                             input logic [1:0] st);
    abus_chipselect     = 3'b111;
    abus_chipselect[cs] = 1'b0;
    abus_address        = a;
    abus_data_in        = d;
    abus_write          = st;
  endtask

  task automatic start_read(input int cs, input logic [9:0] a);
    abus_chipselect     = 3'b111;
    abus_chipselect[cs] = 1'b0;
    abus_address        = a;
    abus_read           = 1'b0;
  endtask

  task automatic bus_write(input int cs, input logic [9:0] a, input logic [15:0] d,
                           input logic [1:0] st);
    @(negedge clk);
    start_write(cs, a, d, st);
    repeat (3) @(negedge clk);
    end_strobes();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit found;
    int held;
    int rd_before;
    logic [30:0] exp_e;

    reset = 1'b1; end_strobes(); abus_address = '0; abus_data_in = '0;
    irq_in = 3'b000; avm_waitrequest = 1'b0; error_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_avm_read", avm_read, 0);
    check("rst_avm_write", avm_write, 0);
    check("rst_abus_wait", abus_waitrequest, 0);
    check("rst_oe", abus_data_oe, 0);
    check("rst_data_out", abus_data_out, 16'h0000);
    check("rst_timeout", timeout_error, 0);
    check("rst_irq", abus_interrupt, 0);
    reset = 1'b0;

    irq_in = 3'b010;
    @(negedge clk); check("irq_set", abus_interrupt, 1);
    irq_in = 3'b000;
    @(negedge clk); check("irq_clr", abus_interrupt, 0);

    // CS0 full-word write
    bus_write(0, 10'h155, 16'hA5C3, 2'b00);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (wq.size() >= 1) begin found = 1; break; end
      @(negedge clk);
    end
    check("t1_write_seen", found, 1);
    if (found) check("t1_entry", wq[0], {13'h02AA, 2'b11, 16'hA5C3});

    // CS2 upper-byte write stalled by 5 clocks of waitrequest
    avm_waitrequest = 1'b1;
    @(negedge clk);
    start_write(2, 10'h2A0, 16'hBEEF, 2'b01);
    exp_e = {13'h1540, 2'b10, 16'hBEEF};
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (avm_write) begin found = 1; break; end
    end
    check("t2_write_seen", found, 1);
    held = 1;
    check("t2_stable", {avm_address, avm_byteenable, avm_writedata}, exp_e);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      held += int'(avm_write);
      check("t2_stable", {avm_address, avm_byteenable, avm_writedata}, exp_e);
    end
    @(negedge clk);
    held += int'(avm_write);
    avm_waitrequest = 1'b0;
    end_strobes();
    @(negedge clk);
    check("t2_popped", avm_write, 0);
    check("t2_held_cycles", held, 6);
    check("t2_wq_size", wq.size(), 2);
    repeat (3) @(negedge clk);

    // Nine writes into a stalled slave: the ninth must back-pressure the A-bus
    avm_waitrequest = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus_write(1, 10'h040 + 10'(i), 16'h1000 + 16'(i), 2'b00);
      check("t3_wait_after_push", abus_waitrequest, (i == 8));
    end
    check("t3_nothing_popped", wq.size(), 2);
    avm_waitrequest = 1'b0;
    @(negedge clk);
    check("t3_wait_released", abus_waitrequest, 0);
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (wq.size() >= 11) begin found = 1; break; end
      @(negedge clk);
    end
    check("t3_all_drained", found, 1);
    if (found) begin
      for (int i = 0; i < 9; i++)
        check("t3_order", wq[2+i], {2'd1, 10'h040 + 10'(i), 1'b0, 2'b11, 16'h1000 + 16'(i)});
    end

    // Read-after-write ordering
    avm_waitrequest = 1'b1;
    rd_before = rd_cnt;
    bus_write(0, 10'h010, 16'h1234, 2'b00);
    start_read(0, 10'h010);
    repeat (6) @(negedge clk);
    check("t4_abus_wait_in_read", abus_waitrequest, 1);
    check("t4_read_held_back", rd_cnt, rd_before);
    avm_waitrequest = 1'b0;
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (abus_data_oe) begin found = 1; break; end
    end
    check("t4_oe", found, 1);
    check("t4_data", abus_data_out, 16'h1234);
    check("t4_wait_low", abus_waitrequest, 0);
    check("t4_writes_before_read", wr_before_rd, 12);
    check("t4_read_addr", rd_addr_seen, 13'h0020);
    end_strobes();
    repeat (4) @(negedge clk);
    check("t4_oe_drop", abus_data_oe, 0);

    // Read timeout
    respond_en = 1'b0;
    start_read(1, 10'h3FF);
    found = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (abus_data_oe) begin found = 1; break; end
    end
    check("t5_oe", found, 1);
    check("t5_data", abus_data_out, 16'hFFFF);
    check("t5_timeout_set", timeout_error, 1);
    check("t5_read_addr", rd_addr_seen, 13'h0FFE);
    end_strobes();
    repeat (4) @(negedge clk);
    check("t5_oe_drop", abus_data_oe, 0);
    check("t5_sticky", timeout_error, 1);
    error_clear = 1'b1;
    @(negedge clk);
    error_clear = 1'b0;
    check("t5_cleared", timeout_error, 0);
    respond_en = 1'b1;

    // Reset during a stalled CS1 read with a queued write behind it
    avm_waitrequest = 1'b1;
    @(negedge clk);
    start_read(1, 10'h100);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (avm_read) begin found = 1; break; end
    end
    check("t6_read_issued", found, 1);
    check("t6_read_addr", avm_address, 13'h0A00);
    abus_data_in = 16'h5555;
    abus_write   = 2'b00;
    repeat (4) @(negedge clk);
    check("t6_write_blocked", avm_write, 0);
    reset = 1'b1;
    end_strobes();
    @(negedge clk);
    reset = 1'b0;
    check("t6_avm_read", avm_read, 0);
    check("t6_avm_write", avm_write, 0);
    check("t6_abus_wait", abus_waitrequest, 0);
    check("t6_oe", abus_data_oe, 0);
    check("t6_data_out", abus_data_out, 16'h0000);
    avm_waitrequest = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_fifo_discarded", wq.size(), 12);
    bus_write(1, 10'h055, 16'h7777, 2'b00);
    repeat (3) @(negedge clk);
    check("t6_post_reset_write", wq.size(), 13);
    if (wq.size() == 13) check("t6_post_reset_entry", wq[12], {13'h08AA, 2'b11, 16'h7777});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/abus_avalon_bridge_v2.md
Name: abus_avalon_bridge_v2

Overview:
Parametrised Saturn A-bus slave front end, the successor to the single-CS A-bus slave inside the wasca system. It samples the asynchronous A-bus strobes and converts cartridge reads and writes into Avalon-MM master transfers toward SDRAM and CSRs. New over the previous generation:
- configurable chip-select count and address width
- posted-write FIFO
- read/write ordering
- read timeout with sticky error
- per-CS interrupt forwarding

Parameters:
ADDR_W, 10, A-bus word-address width per chip select
NUM_CS, 3, number of active-low chip selects (1..4)
SYNC_STAGES, 2, synchroniser depth for all A-bus inputs (2..3)
WFIFO_DEPTH, 8, posted-write FIFO entries (power of two, >=2)
TIMEOUT, 255, Avalon read timeout in clocks (>0)

Ports:
clock  in  1  system clock (116 MHz domain)
reset  in  1  synchronous, active-high reset
abus_address  in  ADDR_W  A-bus word address
abus_chipselect  in  NUM_CS  active-low chip selects
abus_read  in  1  active-low read strobe
abus_write  in  2  active-low byte write strobes, [1]=upper byte
abus_data_in  in  16  data from bus
abus_data_out  out  16  read data to bus
abus_data_oe  out  1  drive enable for abus_data_out
abus_waitrequest  out  1  active-high wait to bus
abus_interrupt  out  1  OR of irq_in
irq_in  in  NUM_CS  interrupt sources
avm_address  out  ADDR_W+3  byte address {cs_idx[1:0], word addr, 1'b0}
avm_read  out  1
avm_write  out  1
avm_byteenable  out  2
avm_writedata  out  16
avm_readdata  in  16
avm_readdatavalid  in  1
avm_waitrequest  in  1
timeout_error  out  1  sticky read-timeout flag
error_clear  in  1  clears timeout_error

Behaviour:
- Reset: all outputs 0, with these exceptions: abus_data_out=16'h0000 and abus_data_oe=0 (both remain 0 after reset). FIFO is emptied. FSM goes to IDLE. timeout_error=0.
- Synchronisation: all abus_* inputs pass through SYNC_STAGES flops.
- Edge detection: events are taken on falling edges of the synchronised read and write strobes.
  - cs_idx is the lowest asserted CS bit.
  - Multiple asserted CS: the lowest index wins.
  - No CS asserted: the strobe is ignored.
- Write path, sampled at the write falling edge:
  - Push {cs_idx, address, ~abus_write, data_in} into the FIFO.
  - FIFO full: assert abus_waitrequest the next cycle and hold it until the push completes. The push completes on the cycle the drainer pops.
  - Strobes deasserted while waiting: the write is still pushed; it is never dropped.
- Drainer: independent of the main FSM.
  - While the FIFO is non-empty and no read is active on Avalon, present the head entry with avm_write=1.
  - Pop on the first cycle with avm_write=1 and avm_waitrequest=0.
  - Outputs hold stable while waitrequest is high.
  - Simultaneous push and pop on a full FIFO is legal; the count stays at DEPTH.
- Main FSM states: IDLE, RD_FLUSH, RD_REQ, RD_WAIT, RD_HOLD.
  - IDLE -> RD_FLUSH on read falling edge with a valid CS. Capture address and cs_idx. Set abus_waitrequest=1.
  - RD_FLUSH -> RD_REQ once the FIFO is empty and the drainer is idle (read-after-write ordering).
  - RD_REQ: avm_read=1, byteenable=2'b11. Hold until avm_waitrequest=0, then go to RD_WAIT. The timeout counter is cleared on that transition.
  - RD_WAIT: on readdatavalid, latch readdata and go to RD_HOLD.
  - RD_WAIT timeout: if the counter reaches TIMEOUT, latch 16'hFFFF, set timeout_error, and go to RD_HOLD. A late readdatavalid is ignored until IDLE.
  - RD_HOLD: abus_waitrequest=0, abus_data_oe=1, abus_data_out=latched data. Return to IDLE when the synchronised read deasserts; oe drops in the same cycle.
  - Read strobe deasserted before RD_HOLD: complete the Avalon read, discard the data, go to IDLE, oe stays 0.
- Timing: minimum read latency from synchronised falling edge to oe is 3 clocks with empty FIFO, zero Avalon waitrequest and readdatavalid one cycle after the accepted read.
- abus_interrupt is the registered OR of irq_in (1 clock latency).
- timeout_error: error_clear clears it unless a new timeout occurs in the same cycle; the set wins.
- Reset mid-transaction: avm_read and avm_write drop the next cycle. Pending FIFO writes are discarded.

Test Plan:
- CS0 write, address 10'h155, data 16'hA5C3, write=2'b00 -> one avm_write at byte address {2'd0,10'h155,1'b0}=13'h02AA, byteenable 2'b11, writedata 16'hA5C3.
- CS2 write, strobes 2'b01 (upper byte only), with avm_waitrequest high for 5 clocks -> avm_write is held 6 clocks with byteenable=2'b10 and stable address and data, then popped.
- 9 back-to-back writes with avm_waitrequest stuck high -> abus_waitrequest rises after the 8th push. It falls once waitrequest is released and the 9th write is accepted. The 9 writes appear in order.
- Write 16'h1234 to 0x010, then immediately read 0x010 -> avm_read is issued only after the write is accepted. abus_data_out=16'h1234 with oe=1.
- Read with readdatavalid never asserted, TIMEOUT=255 -> abus_data_out=16'hFFFF and timeout_error=1. error_clear=1 for one clock -> timeout_error=0.
- Read in progress on CS1, then reset asserted one clock -> all outputs 0 the next cycle, FIFO empty, FSM in IDLE.
